onchip_mem_fill_check: RTL and testbench

- Avalon-MM initiator that drives the s1 slave port of the single-port on-chip RAM (51200 x 32, word-addressed, no waitrequest, fixed read latency 1).
- Fills a contiguous word range with a programmable pattern and/or reads the range back and compares it against the same pattern.
- Used as a boot-time memory clear and as a hardware self-test engine, arbitrated ahead of the Nios II data master.

---
 rtl/onchip_mem_fill_check_pkg.sv | 22 ++
 rtl/onchip_mem_fill_check_pattern.sv | 19 +
 rtl/onchip_mem_fill_check.sv | 153 +++++++++++++++
 tb/tb_onchip_mem_fill_check.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_fill_check_pkg.sv
// Shared definitions for the on-chip RAM fill/check engine and the RAM wrapper.
package onchip_mem_fill_check_pkg;

    localparam int RAM_DEPTH  = 51200;
    localparam int RAM_ADDR_W = 16;

    typedef enum logic [1:0] {
        OP_FILL       = 2'd0,
        OP_CHECK      = 2'd1,
        OP_FILL_CHECK = 2'd2,
        OP_RSVD       = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/onchip_mem_fill_check_pattern.sv
// Pattern source shared by the write data path and the expected-data path.
module mem_pattern_gen
    import onchip_mem_fill_check_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 17
) (
    input  logic              pat_inc,
    input  logic [DATA_W-1:0] seed,
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] pattern
);

    logic [DATA_W-1:0] idx_ext;

    assign idx_ext = DATA_W'(idx);
    assign pattern = pat_inc ? seed + idx_ext : seed;

endmodule

// File: rtl/onchip_mem_fill_check.sv
// Avalon-MM initiator that fills a RAM word range with a pattern and/or reads it back and compares.
module onchip_mem_fill_check
    import onchip_mem_fill_check_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = 32,
    parameter int DEPTH  = RAM_DEPTH,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            op,
    input  logic                  pat_inc,
    input  logic [DATA_W-1:0]     seed,
    input  logic [ADDR_W-1:0]     base,
    input  logic [ADDR_W:0]       length,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic                  aborted,
    output logic                  mismatch,
    output logic [CNT_W-1:0]      err_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic [DATA_W-1:0]     first_err_data,
    output logic [ADDR_W-1:0]     m_address,
    output logic [DATA_W/8-1:0]   m_byteenable,
    output logic                  m_chipselect,
    output logic                  m_write,
    output logic [DATA_W-1:0]     m_writedata,
    input  logic [DATA_W-1:0]     m_readdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = ADDR_W + 1;
    localparam logic [ADDR_W+1:0] DEPTH_X = (ADDR_W+2)'(DEPTH);

    state_e              state, nxt;
    logic [1:0]          op_q;
    logic                pat_inc_q;
    logic [DATA_W-1:0]   seed_q;
    logic [ADDR_W-1:0]   base_q;
    logic [IDX_W-1:0]    len_q, idx;
    logic                rd_vld;
    logic [DATA_W-1:0]   exp_q;
    logic [ADDR_W-1:0]   exp_addr_q;
    logic [DATA_W-1:0]   pat;
    logic                last, req_bad, start_ok, active;

    assign start_ok = (state == ST_IDLE) && start;
    assign active   = (state == ST_WRITE) || (state == ST_READ);
    assign last     = (idx == len_q - IDX_W'(1));
    assign req_bad  = (op == OP_RSVD) || (length == '0) ||
                      ({1'b0, length} > DEPTH_X) ||
                      (({2'b00, base} + {1'b0, length}) > DEPTH_X);

    mem_pattern_gen #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_pat (
        .pat_inc (pat_inc_q),
        .seed    (seed_q),
        .idx     (idx),
        .pattern (pat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= nxt;
    end

    // abort is sampled at the edge closing a cycle, so the access already on the
    // bus in that cycle completes; no further accesses are issued afterwards.
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (start) nxt = req_bad ? ST_DONE :
                                       (op == OP_CHECK) ? ST_READ : ST_WRITE;
            ST_WRITE: if (abort || (last && op_q == OP_FILL)) nxt = ST_DONE;
                      else if (last)                           nxt = ST_READ;
            ST_READ:  if (abort || last) nxt = ST_DRAIN;
            ST_DRAIN: nxt = ST_DONE;
            ST_DONE:  nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m_chipselect = active;
        m_write      = (state == ST_WRITE);
        m_address    = active ? base_q + idx[ADDR_W-1:0] : '0;
        m_writedata  = (state == ST_WRITE) ? pat : '0;
        m_byteenable = {BE_W{active}};
        busy         = active || (state == ST_DRAIN);
        done         = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q           <= '0;
            pat_inc_q      <= 1'b0;
            seed_q         <= '0;
            base_q         <= '0;
            len_q          <= '0;
            idx            <= '0;
            rd_vld         <= 1'b0;
            exp_q          <= '0;
            exp_addr_q     <= '0;
            cfg_err        <= 1'b0;
            aborted        <= 1'b0;
            mismatch       <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else begin
            rd_vld <= (state == ST_READ);
            if (state == ST_READ) begin
                exp_q      <= pat;
                exp_addr_q <= m_address;
            end

            if (start_ok) begin
                op_q           <= op;
                pat_inc_q      <= pat_inc;
                seed_q         <= seed;
                base_q         <= base;
                len_q          <= length;
                idx            <= '0;
                cfg_err        <= req_bad;
                aborted        <= 1'b0;
                mismatch       <= 1'b0;
                err_count      <= '0;
                first_err_addr <= '0;
                first_err_data <= '0;
            end else if (state == ST_WRITE && last) begin
                idx <= '0;
            end else if (active) begin
                idx <= idx + IDX_W'(1);
            end

            if (active && abort) aborted <= 1'b1;

            // Read data returns one cycle after the read; compare against the registered expectation.
            if (rd_vld && (m_readdata != exp_q)) begin
                mismatch <= 1'b1;
                if (err_count != '1) err_count <= err_count + CNT_W'(1);
                if (!mismatch) begin
                    first_err_addr <= exp_addr_q;
                    first_err_data <= m_readdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_onchip_mem_fill_check.sv
// Directed bench for onchip_mem_fill_check against a behavioural 1-cycle-latency RAM.
module tb_onchip_mem_fill_check;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 51200;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0, reset_n = 1'b0;
    logic              start = 1'b0, abort = 1'b0, pat_inc = 1'b0;
    logic [1:0]        op = '0;
    logic [31:0]       seed = '0;
    logic [15:0]       base = '0;
    logic [16:0]       length = '0;
    logic              busy, done, cfg_err, aborted, mismatch;
    logic [15:0]       err_count, first_err_addr, m_address;
    logic [31:0]       first_err_data, m_writedata;
    logic [31:0]       m_readdata = '0;
    logic [3:0]        m_byteenable;
    logic              m_chipselect, m_write;

    logic [31:0] mem [0:DEPTH-1];
    int nchk = 0, nfail = 0, cyc = 0, busy_cnt = 0, be_bad = 0, k = 0;
    logic [15:0] wr_addr[$], rd_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$], rd_cyc[$];

    onchip_mem_fill_check #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .op(op),
        .pat_inc(pat_inc), .seed(seed), .base(base), .length(length),
        .busy(busy), .done(done), .cfg_err(cfg_err), .aborted(aborted),
        .mismatch(mismatch), .err_count(err_count), .first_err_addr(first_err_addr),
        .first_err_data(first_err_data), .m_address(m_address),
        .m_byteenable(m_byteenable), .m_chipselect(m_chipselect), .m_write(m_write),
        .m_writedata(m_writedata), .m_readdata(m_readdata)
    );

    always #5 clk = ~clk;

    // RAM model plus bus recorder
    always @(posedge clk) begin
        cyc++;
        if (busy) busy_cnt++;
        if (m_byteenable != (m_chipselect ? 4'hF : 4'h0)) be_bad++;
        if (m_chipselect) begin
            if (m_write) begin
                mem[m_address] <= m_writedata;
                wr_addr.push_back(m_address);
                wr_data.push_back(m_writedata);
                wr_cyc.push_back(cyc);
            end else begin
                m_readdata <= mem[m_address];
                rd_addr.push_back(m_address);
                rd_cyc.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic go(input logic [1:0] o, input logic pi, input logic [31:0] s,
                      input logic [15:0] b, input logic [16:0] l);
        wr_addr.delete(); rd_addr.delete(); wr_data.delete();
        wr_cyc.delete(); rd_cyc.delete();
        busy_cnt = 0;
        op = o; pat_inc = pi; seed = s; base = b; length = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) chk({tag, " timeout"}, done, 1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        #3;
        chk("rst cs",   m_chipselect, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst flags", {cfg_err, aborted, mismatch}, 0);
        chk("rst cnt",  err_count, 0);
        chk("rst addr", m_address, 0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Constant fill
        go(2'd0, 1'b0, 32'hDEADBEEF, 16'h0100, 17'd4);
        wait_done("fill", 20, k);
        chk("fill lat", k, 4);
        @(posedge clk); #1;
        chk("fill done pulse", done, 0);
        chk("fill busy cycles", busy_cnt, 4);
        chk("fill nwr", wr_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fill addr%0d", i), wr_addr[i], 16'h0100 + i);
            chk($sformatf("fill data%0d", i), wr_data[i], 32'hDEADBEEF);
        end
        chk("fill contiguous", wr_cyc[3] - wr_cyc[0], 3);
        chk("fill mismatch", mismatch, 0);

        // Incrementing fill then check, wrapping the pattern
        go(2'd2, 1'b1, 32'hFFFFFFFE, 16'h0000, 17'd3);
        wait_done("fc", 30, k);
        chk("fc lat", k, 7);
        @(posedge clk); #1;
        chk("fc nwr", wr_addr.size(), 3);
        chk("fc wd0", wr_data[0], 32'hFFFFFFFE);
        chk("fc wd1", wr_data[1], 32'hFFFFFFFF);
        chk("fc wd2", wr_data[2], 32'h00000000);
        chk("fc nrd", rd_addr.size(), 3);
        chk("fc no gap", rd_cyc[0] - wr_cyc[2], 1);
        chk("fc busy cycles", busy_cnt, 7);
        chk("fc errs", err_count, 0);
        chk("fc mismatch", mismatch, 0);

        // Check with two corrupted words
        for (int i = 16'h20; i < 16'h28; i++) mem[i] = 32'd5;
        mem[16'h23] = 32'd7;
        mem[16'h25] = 32'd9;
        go(2'd1, 1'b0, 32'd5, 16'h0020, 17'd8);
        wait_done("chk", 30, k);
        chk("chk lat", k, 9);
        chk("chk errs", err_count, 2);
        chk("chk first addr", first_err_addr, 16'h0023);
        chk("chk first data", first_err_data, 32'd7);
        chk("chk mismatch", mismatch, 1);
        chk("chk nwr", wr_addr.size(), 0);
        chk("chk nrd", rd_addr.size(), 8);
        @(posedge clk); #1;

        // Config errors: range overrun, zero length, reserved op
        go(2'd0, 1'b0, 32'h1, 16'd51190, 17'd11);
        wait_done("cfg range", 5, k);
        chk("cfg range lat", k, 0);
        chk("cfg range flag", cfg_err, 1);
        @(posedge clk); #1;
        chk("cfg range busy", busy_cnt, 0);
        chk("cfg range bus", wr_addr.size() + rd_addr.size(), 0);
        chk("cfg sticky", cfg_err, 1);

        go(2'd1, 1'b0, 32'h1, 16'h0010, 17'd0);
        wait_done("cfg len0", 5, k);
        chk("cfg len0 lat", k, 0);
        chk("cfg len0 flag", cfg_err, 1);
        @(posedge clk); #1;
        chk("cfg len0 bus", wr_addr.size() + rd_addr.size() + busy_cnt, 0);

        go(2'd3, 1'b0, 32'h1, 16'h0010, 17'd4);
        wait_done("cfg op3", 5, k);
        chk("cfg op3 lat", k, 0);
        chk("cfg op3 flag", cfg_err, 1);
        @(posedge clk); #1;
        chk("cfg op3 bus", wr_addr.size() + rd_addr.size() + busy_cnt, 0);

        // Exactly touching the top of the RAM is legal
        go(2'd0, 1'b0, 32'h12345678, 16'd51190, 17'd10);
        wait_done("edge", 30, k);
        chk("edge cfg", cfg_err, 0);
        chk("edge nwr", wr_addr.size(), 10);
        chk("edge last addr", wr_addr[9], 16'd51199);
        @(posedge clk); #1;

        // Abort on the 10th read; that read is still issued and compared
        for (int i = 16'h200; i < 16'h264; i++) mem[i] = '0;
        mem[16'h209] = 32'h00000BAD;
        go(2'd1, 1'b0, 32'h0, 16'h0200, 17'd100);
        repeat (9) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_done("abort", 10, k);
        chk("abort nrd", rd_addr.size(), 10);
        chk("abort last rd", rd_addr[9], 16'h0209);
        chk("abort flag", aborted, 1);
        chk("abort errs", err_count, 1);
        chk("abort first addr", first_err_addr, 16'h0209);
        chk("abort first data", first_err_data, 32'h00000BAD);
        @(posedge clk); #1;

        // Reset in the middle of a fill
        go(2'd0, 1'b0, 32'hCAFEF00D, 16'h0300, 17'd50);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid rst cs", {m_chipselect, m_write}, 0);
        chk("mid rst busy/done", {busy, done}, 0);
        chk("mid rst flags", {aborted, mismatch, cfg_err}, 0);
        chk("mid rst cnt", err_count, 0);
        chk("mid rst first", {first_err_addr, first_err_data}, 0);
        chk("mid rst bus", {m_address, m_writedata, m_byteenable}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        go(2'd2, 1'b0, 32'hA5A5A5A5, 16'h0400, 17'd5);
        wait_done("post rst", 40, k);
        chk("post rst lat", k, 11);
        chk("post rst nwr", wr_addr.size(), 5);
        chk("post rst nrd", rd_addr.size(), 5);
        chk("post rst errs", err_count, 0);
        chk("post rst mismatch", mismatch, 0);
        @(posedge clk); #1;
        chk("byteenable", be_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
